// File: rtl/trade_report_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trade_report_tx_pkg
// Desc     : Shared constants, FSM encodings and record type for trade reporting
// Revision : 1.0
// ============================================================================
package trade_report_tx_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_BYTES   = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef struct packed {
    logic [7:0] count;
    logic [7:0] price;
    logic [7:0] bid;
    logic [7:0] ask;
  } trade_rec_t;

  // Frame byte idx 1..4 maps onto the record; idx 0 is the sync byte.
  function automatic logic [7:0] rec_byte(input trade_rec_t rec, input logic [2:0] idx);
    case (idx)
      3'd1:    return rec.count;
      3'd2:    return rec.price;
      3'd3:    return rec.bid;
      default: return rec.ask;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/trade_report_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : trade_report_tx_if
// Desc     : Engine tap inputs and UART/status outputs of the trade reporter
// Revision : 1.0
// ============================================================================
interface trade_report_tx_if;
  logic       match_signal;
  logic       halt_signal;
  logic [7:0] trade_price;
  logic [7:0] best_bid;
  logic [7:0] best_ask;
  logic [7:0] trade_count;
  logic       uart_tx;
  logic       tx_busy;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  modport master (
    output match_signal, halt_signal, trade_price, best_bid, best_ask, trade_count,
    input  uart_tx, tx_busy, fifo_level, overflow, drop_count
  );

  modport slave (
    input  match_signal, halt_signal, trade_price, best_bid, best_ask, trade_count,
    output uart_tx, tx_busy, fifo_level, overflow, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/trade_report_tx_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Desc     : 8N1 byte serialiser; accepts a back-to-back start in the last stop cycle
// Revision : 1.0
// ============================================================================
module uart_byte_tx
  import trade_report_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_bit_end;

  assign w_bit_end = (r_baud_cnt == CNT_MAX);
  assign done      = (r_state == ST_STOP) && w_bit_end;
  assign tx        = r_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud_cnt <= '0;
          if (start) begin
            r_shift <= data;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_tx       <= r_shift[0];
            r_state    <= ST_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            // Chaining straight into the next start bit keeps bytes gapless.
            if (start) begin
              r_shift <= data;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/trade_report_tx.sv
`default_nettype none
// ============================================================================
// Module   : trade_report_tx
// Desc     : Captures executed trades into a FIFO and sends 5-byte UART report frames
// Revision : 1.0
// ============================================================================
module trade_report_tx
  import trade_report_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  trade_report_tx_if.slave  bus
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LEVEL_MAX = 4'(FIFO_DEPTH);
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_BYTES - 1);

  trade_rec_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [3:0]    r_level;
  logic          r_match_prev;
  logic          r_overflow;
  logic [7:0]    r_drop_count;
  trade_rec_t    r_frame;
  logic          r_frame_active;
  logic [2:0]    r_byte_idx;

  trade_rec_t    w_in_rec;
  logic          w_capture;
  logic          w_pop;
  logic          w_push;
  logic          w_next_byte;
  logic          w_start;
  logic          w_done;
  logic          w_tx;
  logic [7:0]    w_byte_data;

  assign w_in_rec    = '{count: bus.trade_count, price: bus.trade_price,
                         bid: bus.best_bid, ask: bus.best_ask};
  assign w_capture   = bus.match_signal && !r_match_prev && !bus.halt_signal;
  // A new frame starts from idle or directly out of the last stop bit.
  assign w_pop       = (r_level != 4'd0) &&
                       (!r_frame_active || (w_done && r_byte_idx == LAST_IDX));
  assign w_push      = w_capture && ((r_level < LEVEL_MAX) || w_pop);
  assign w_next_byte = r_frame_active && w_done && (r_byte_idx != LAST_IDX);
  assign w_start     = w_pop || w_next_byte;
  assign w_byte_data = w_pop ? SYNC_BYTE : rec_byte(r_frame, r_byte_idx + 3'd1);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= 4'd0;
      r_match_prev <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_match_prev <= bus.match_signal;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
      if (w_capture && !w_push) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame        <= '0;
      r_frame_active <= 1'b0;
      r_byte_idx     <= 3'd0;
    end else if (w_pop) begin
      r_frame        <= r_mem[r_rd_ptr];
      r_frame_active <= 1'b1;
      r_byte_idx     <= 3'd0;
    end else if (w_next_byte) begin
      r_byte_idx     <= r_byte_idx + 3'd1;
    end else if (w_done && r_frame_active) begin
      r_frame_active <= 1'b0;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .data  (w_byte_data),
    .tx    (w_tx),
    .done  (w_done)
  );

  assign bus.uart_tx    = w_tx;
  assign bus.tx_busy    = r_frame_active || (r_level != 4'd0);
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_trade_report_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_trade_report_tx
// Desc     : Directed table-driven bench with a UART line decoder
// Revision : 1.0
// ============================================================================
module tb_trade_report_tx;

  localparam int CPB       = 8;
  localparam int FRAME_CYC = 50 * CPB;

  typedef struct {
    logic [7:0]  cnt;
    logic [7:0]  price;
    logic [7:0]  bid;
    logic [7:0]  ask;
    logic [39:0] exp_frame;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trade_report_tx_if bus ();

  trade_report_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         framing_err = 0;
  logic [7:0] rx_q[$];
  vec_t       tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line decoder: samples mid-bit on negedges and queues each received byte.
  initial begin : decoder
    logic [7:0] b;
    b = 8'd0;
    wait (!reset);
    forever begin
      @(negedge clk);
      if (bus.uart_tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (bus.uart_tx !== 1'b0) framing_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (bus.uart_tx !== 1'b1) framing_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic drive_vec(input vec_t v);
    bus.trade_count = v.cnt;
    bus.trade_price = v.price;
    bus.best_bid    = v.bid;
    bus.best_ask    = v.ask;
  endtask

  task automatic pulse(input vec_t v);
    @(negedge clk);
    drive_vec(v);
    bus.match_signal = 1'b1;
    @(negedge clk);
    bus.match_signal = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (bus.tx_busy && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("idle_timeout", 64'(bus.tx_busy), 64'd0);
  endtask

  task automatic get_frame(output logic [39:0] f);
    f = 40'd0;
    for (int i = 0; i < 5; i++)
      if (rx_q.size() > 0) f = {f[31:0], rx_q.pop_front()};
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int          cyc;
    int          max_lvl;
    logic [39:0] f;

    tbl[0] = '{8'h01, 8'h64, 8'h65, 8'h63, 40'hA5_01_64_65_63};
    tbl[1] = '{8'h02, 8'h65, 8'h66, 8'h64, 40'hA5_02_65_66_64};
    tbl[2] = '{8'h03, 8'h6A, 8'h6B, 8'h69, 40'hA5_03_6A_6B_69};
    tbl[3] = '{8'h04, 8'h00, 8'hFF, 8'h01, 40'hA5_04_00_FF_01};
    tbl[4] = '{8'h05, 8'hFF, 8'h00, 8'h80, 40'hA5_05_FF_00_80};
    tbl[5] = '{8'h06, 8'h55, 8'hAA, 8'h0F, 40'hA5_06_55_AA_0F};
    tbl[6] = '{8'h07, 8'h80, 8'h7F, 8'h81, 40'hA5_07_80_7F_81};
    tbl[7] = '{8'h08, 8'h12, 8'h34, 8'h56, 40'hA5_08_12_34_56};
    tbl[8] = '{8'h09, 8'hF0, 8'h0E, 8'hA5, 40'hA5_09_F0_0E_A5};
    tbl[9] = '{8'h0A, 8'h11, 8'h22, 8'h33, 40'hA5_0A_11_22_33};

    bus.match_signal = 1'b0;
    bus.halt_signal  = 1'b0;
    drive_vec(tbl[0]);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 64'(bus.uart_tx), 64'd1);
    check("rst_tx_busy", 64'(bus.tx_busy), 64'd0);
    check("rst_fifo_level", 64'(bus.fifo_level), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_drop_count", 64'(bus.drop_count), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single trade: latency, frame length, content; inputs change mid-frame
    pulse(tbl[0]);
    check("t2_level_after_push", 64'(bus.fifo_level), 64'd1);
    check("t2_tx_idle_before_pop", 64'(bus.uart_tx), 64'd1);
    check("t2_busy", 64'(bus.tx_busy), 64'd1);
    @(posedge clk);
    #1;
    check("t2_start_bit", 64'(bus.uart_tx), 64'd0);
    check("t2_level_after_pop", 64'(bus.fifo_level), 64'd0);
    drive_vec(tbl[9]);
    wait_idle(FRAME_CYC + 50, cyc);
    check("t2_frame_cycles", 64'(cyc), 64'(FRAME_CYC));
    repeat (4) @(negedge clk);
    check("t2_rx_bytes", 64'(rx_q.size()), 64'd5);
    get_frame(f);
    check("t2_frame", 64'(f), 64'(tbl[0].exp_frame));

    // Held-high match gives one record
    @(negedge clk);
    drive_vec(tbl[1]);
    bus.match_signal = 1'b1;
    max_lvl = 0;
    repeat (10) begin
      @(negedge clk);
      if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
    end
    bus.match_signal = 1'b0;
    check("t3_peak_level", 64'(max_lvl), 64'd1);
    wait_idle(2 * FRAME_CYC, cyc);
    repeat (CPB) @(negedge clk);
    check("t3_rx_bytes", 64'(rx_q.size()), 64'd5);
    get_frame(f);
    check("t3_frame", 64'(f), 64'(tbl[1].exp_frame));

    // Burst of 10: 9 accepted, 10th dropped
    for (int i = 0; i < 10; i++) begin
      pulse(tbl[i]);
      repeat (2) @(negedge clk);
    end
    check("t4_overflow", 64'(bus.overflow), 64'd1);
    check("t4_drop_count", 64'(bus.drop_count), 64'd1);
    check("t4_level_full", 64'(bus.fifo_level), 64'd8);
    wait_idle(9 * FRAME_CYC + 100, cyc);
    repeat (CPB) @(negedge clk);
    check("t4_rx_bytes", 64'(rx_q.size()), 64'd45);
    for (int i = 0; i < 9; i++) begin
      get_frame(f);
      check($sformatf("t4_frame%0d", i), 64'(f), 64'(tbl[i].exp_frame));
    end

    // Reset clears sticky status; halted match is discarded silently
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_overflow_cleared", 64'(bus.overflow), 64'd0);
    check("t5_drop_cleared", 64'(bus.drop_count), 64'd0);
    bus.halt_signal = 1'b1;
    pulse(tbl[2]);
    repeat (2) @(negedge clk);
    check("t5_level", 64'(bus.fifo_level), 64'd0);
    check("t5_busy", 64'(bus.tx_busy), 64'd0);
    check("t5_drop", 64'(bus.drop_count), 64'd0);
    bus.halt_signal = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("t5_no_frame", 64'(rx_q.size()), 64'd0);

    // Reset mid-frame (byte 2, data bits), then a clean frame
    pulse(tbl[3]);
    repeat (20 * CPB + 3 * CPB) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_tx_high_in_reset", 64'(bus.uart_tx), 64'd1);
    check("t6_level_in_reset", 64'(bus.fifo_level), 64'd0);
    check("t6_busy_in_reset", 64'(bus.tx_busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx_q.delete();
    pulse(tbl[4]);
    wait_idle(FRAME_CYC + 50, cyc);
    repeat (4) @(negedge clk);
    check("t6_rx_bytes", 64'(rx_q.size()), 64'd5);
    get_frame(f);
    check("t6_frame", 64'(f), 64'(tbl[4].exp_frame));

    check("framing_errors", 64'(framing_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
